// File: rtl/screen_packet_sender_pkg.sv
// Shared definitions for the screen-update frame sender: byte constants,
// frame-entry layout and the serialiser state encoding.
package screen_packet_sender_pkg;

  // Frame delimiter and the value sent in its place when it appears as data
  localparam logic [7:0] SYNC_BYTE  = 8'hFF;
  localparam logic [7:0] SUBST_BYTE = 8'hFE;

  // Request field widths
  localparam int POS_W   = 13;
  localparam int CHAR_W  = 8;
  localparam int COLOR_W = 8;
  localparam int ENTRY_W = POS_W + CHAR_W + COLOR_W;

  // Field offsets inside a queued entry {pos, char, color}
  localparam int COLOR_LSB = 0;
  localparam int CHAR_LSB  = COLOR_LSB + COLOR_W;
  localparam int POS_LSB   = CHAR_LSB + CHAR_W;

  // Serialiser states, one per frame byte plus idle
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_POS_HI,
    ST_POS_LO,
    ST_CHAR,
    ST_COLOR
  } tx_state_e;

  // Data bytes must never look like a sync byte to the receiver
  function automatic logic [7:0] escape_byte(input logic [7:0] b);
    return (b == SYNC_BYTE) ? SUBST_BYTE : b;
  endfunction

endpackage

// File: rtl/screen_packet_sender_req_fifo.sv
// Small show-ahead request FIFO. Head entry is visible on rdata whenever
// the FIFO is not empty; pushes when full and pops when empty are dropped.
module screen_req_fifo
  import screen_packet_sender_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               push_ok;
  logic               pop_ok;

  // Flattened view of all storage entries for the head read mux
  logic [DEPTH-1:0][ENTRY_W-1:0] entries;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign level   = count_reg;
  // Space is judged on the registered count, so a same-cycle pop never
  // makes room for a push.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = entries[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ENTRY_W-1:0] entry_reg;
      // Capture the pushed request into the slot the write pointer selects
      always_ff @(posedge clock) begin
        if (push_ok && (wr_ptr_reg == FIFO_AW'(gi))) begin
          entry_reg <= wdata;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; pointers wrap modulo depth
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/screen_packet_sender.sv
// Host-side screen-update transmitter: queues cell writes and serialises
// each one as a 5-byte frame (sync, pos hi, pos lo, char, color) toward a
// byte-wide UART transmitter over a valid/ready handshake.
module screen_packet_sender
  import screen_packet_sender_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [POS_W-1:0]   req_pos,
  input  logic [CHAR_W-1:0]  req_char,
  input  logic [COLOR_W-1:0] req_color,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [FIFO_AW:0]   level,
  output logic               subst_pulse
);

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  tx_state_e          state_reg;
  logic [ENTRY_W-1:0] frame_reg;
  logic [7:0]         tx_data_reg;
  logic               tx_valid_reg;
  logic               subst_pulse_reg;

  logic [POS_W-1:0]   frame_pos;
  logic [CHAR_W-1:0]  frame_char;
  logic [COLOR_W-1:0] frame_color;

  assign req_ready   = !fifo_full;
  assign fifo_push   = req_valid && req_ready;
  // A new frame only starts from idle with work queued and sending enabled
  assign fifo_pop    = (state_reg == ST_IDLE) && enable && !fifo_empty;

  assign frame_pos   = frame_reg[POS_LSB +: POS_W];
  assign frame_char  = frame_reg[CHAR_LSB +: CHAR_W];
  assign frame_color = frame_reg[COLOR_LSB +: COLOR_W];

  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign subst_pulse = subst_pulse_reg;

  screen_req_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({req_pos, req_char, req_color}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Frame serialiser: each byte is held until the UART accepts it, then the
  // next one is loaded. Returning to idle always costs one cycle, so every
  // frame is re-announced with its own sync byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      frame_reg       <= '0;
      tx_data_reg     <= 8'h00;
      tx_valid_reg    <= 1'b0;
      subst_pulse_reg <= 1'b0;
    end else begin
      subst_pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fifo_pop) begin
            frame_reg    <= fifo_head;
            tx_data_reg  <= SYNC_BYTE;
            tx_valid_reg <= 1'b1;
            state_reg    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (tx_ready) begin
            // Top bit forced low so a position byte can never equal sync
            tx_data_reg <= {1'b0, frame_pos[12:6]};
            state_reg   <= ST_POS_HI;
          end
        end
        ST_POS_HI: begin
          if (tx_ready) begin
            tx_data_reg <= {2'b00, frame_pos[5:0]};
            state_reg   <= ST_POS_LO;
          end
        end
        ST_POS_LO: begin
          if (tx_ready) begin
            tx_data_reg     <= escape_byte(frame_char);
            subst_pulse_reg <= (frame_char == SYNC_BYTE);
            state_reg       <= ST_CHAR;
          end
        end
        ST_CHAR: begin
          if (tx_ready) begin
            tx_data_reg     <= escape_byte(frame_color);
            subst_pulse_reg <= (frame_color == SYNC_BYTE);
            state_reg       <= ST_COLOR;
          end
        end
        ST_COLOR: begin
          if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: begin
          tx_valid_reg <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_screen_packet_sender.sv
// Directed bench for screen_packet_sender: frame contents, latency,
// backpressure, full FIFO, substitution, reset and enable behaviour.
module tb_screen_packet_sender;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_pos;
  logic [7:0]  req_char;
  logic [7:0]  req_color;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  level;
  logic        subst_pulse;

  int n_vec = 0;
  int n_err = 0;
  int subst_cnt = 0;
  logic [7:0] cap_q[$];

  screen_packet_sender #(.FIFO_AW(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pos     (req_pos),
    .req_char    (req_char),
    .req_color   (req_color),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .level       (level),
    .subst_pulse (subst_pulse)
  );

  always #5 clock = ~clock;

  // Record accepted bytes and substitution pulses mid-cycle
  always @(negedge clock) begin
    if (tx_valid && tx_ready) cap_q.push_back(tx_data);
    if (subst_pulse) subst_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [12:0] p, input logic [7:0] c, input logic [7:0] co);
    req_valid = 1'b1;
    req_pos   = p;
    req_char  = c;
    req_color = co;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (cap_q.size() >= n) break;
      tick();
    end
    check({tag, "_count"}, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic wait_data(input logic [7:0] d, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (tx_valid === 1'b1 && tx_data === d) break;
      tick();
    end
    check({tag, "_reach"}, 32'(tx_valid === 1'b1 && tx_data === d), 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [12:0] p,
                              input logic [7:0] c, input logic [7:0] co);
    logic [7:0]  exp [5];
    logic [31:0] got;
    exp[0] = 8'hFF;
    exp[1] = {1'b0, p[12:6]};
    exp[2] = {2'b00, p[5:0]};
    exp[3] = (c == 8'hFF) ? 8'hFE : c;
    exp[4] = (co == 8'hFF) ? 8'hFE : co;
    for (int k = 0; k < 5; k++) begin
      if (cap_q.size() != 0) got = {24'h0, cap_q.pop_front()};
      else got = 32'hBAD;
      check($sformatf("%s_b%0d", tag, k), got, {24'h0, exp[k]});
    end
    $display("frame %s: pos=%h char=%h color=%h checked", tag, p, c, co);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; req_valid = 1'b0; tx_ready = 1'b1;
    req_pos = '0; req_char = '0; req_color = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_subst", 32'(subst_pulse), 32'd0);

    // Single frame with latency check
    cap_q.delete();
    push(13'h0ABC, 8'h41, 8'h1F);
    check("lat_c1_valid", 32'(tx_valid), 32'd0);
    tick();
    check("lat_c2_valid", 32'(tx_valid), 32'd1);
    check("lat_c2_data", 32'(tx_data), 32'hFF);
    wait_bytes(5, 20, "single");
    expect_frame("single", 13'h0ABC, 8'h41, 8'h1F);
    repeat (3) tick();

    // Backpressure during POS_LO
    cap_q.delete();
    push(13'h0ABC, 8'h41, 8'h1F);
    wait_data(8'h3C, "bp");
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", k), 32'(tx_valid), 32'd1);
      check($sformatf("bp_hold_data%0d", k), 32'(tx_data), 32'h3C);
    end
    tx_ready = 1'b1;
    wait_bytes(5, 20, "bp");
    expect_frame("bp", 13'h0ABC, 8'h41, 8'h1F);
    repeat (3) tick();

    // Full FIFO with sending disabled
    enable = 1'b0;
    cap_q.delete();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("full_rdy%0d", i), 32'(req_ready), 32'(i < 8));
      push(13'(13'h0111 * i), 8'(8'h30 + i), 8'(8'hA0 + i));
    end
    check("full_level", 32'(level), 32'd8);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_no_tx", 32'(tx_valid), 32'd0);
    enable = 1'b1;
    wait_bytes(40, 200, "full");
    for (int i = 0; i < 8; i++) begin
      expect_frame($sformatf("full%0d", i), 13'(13'h0111 * i), 8'(8'h30 + i), 8'(8'hA0 + i));
    end
    repeat (3) tick();
    check("full_drained", 32'(level), 32'd0);

    // 0xFF substitution in char and color
    cap_q.delete();
    subst_cnt = 0;
    push(13'h0000, 8'hFF, 8'hFF);
    wait_bytes(5, 20, "subst");
    expect_frame("subst", 13'h0000, 8'hFF, 8'hFF);
    tick();
    check("subst_pulses", 32'(subst_cnt), 32'd2);
    repeat (3) tick();

    // Reset in the CHAR state with two entries still queued
    enable = 1'b0;
    push(13'h0ABC, 8'h55, 8'h66);
    push(13'h0123, 8'h42, 8'h20);
    push(13'h0456, 8'h43, 8'h21);
    enable = 1'b1;
    wait_data(8'h55, "rstmid");
    check("rstmid_level_pre", 32'(level), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_valid", 32'(tx_valid), 32'd0);
    check("rstmid_level", 32'(level), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_data", 32'(tx_data), 32'h00);
    cap_q.delete();
    repeat (20) tick();
    check("rstmid_quiet", 32'(cap_q.size()), 32'd0);
    check("rstmid_valid_late", 32'(tx_valid), 32'd0);

    // Enable dropped in POS_HI: current frame finishes, next is held
    enable = 1'b0;
    push(13'h0ABC, 8'h41, 8'h1F);
    push(13'h0123, 8'h42, 8'h20);
    cap_q.delete();
    enable = 1'b1;
    wait_data(8'h2A, "endrop");
    enable = 1'b0;
    check("endrop_level_mid", 32'(level), 32'd1);
    repeat (20) tick();
    check("endrop_nbytes", 32'(cap_q.size()), 32'd5);
    expect_frame("endrop", 13'h0ABC, 8'h41, 8'h1F);
    check("endrop_level_held", 32'(level), 32'd1);
    check("endrop_idle", 32'(tx_valid), 32'd0);
    enable = 1'b1;
    wait_bytes(5, 20, "endrop_resume");
    expect_frame("endrop_resume", 13'h0123, 8'h42, 8'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
